// File: rtl/key_pkg.sv
// Shared types and constants for the keypad front end.
// Key codes are {row_idx, col_idx} of the matrix position.
package key_pkg;

    typedef enum logic [2:0] {
        SCAN     = 3'd0,
        DEBOUNCE = 3'd1,
        PRESS    = 3'd2,
        HELD     = 3'd3,
        RELEASE  = 3'd4
    } scan_state_t;

    localparam logic [3:0] KEY_0    = 4'h0;
    localparam logic [3:0] KEY_1    = 4'h1;
    localparam logic [3:0] KEY_2    = 4'h2;
    localparam logic [3:0] KEY_3    = 4'h3;
    localparam logic [3:0] KEY_4    = 4'h4;
    localparam logic [3:0] KEY_5    = 4'h5;
    localparam logic [3:0] KEY_6    = 4'h6;
    localparam logic [3:0] KEY_7    = 4'h7;
    localparam logic [3:0] KEY_8    = 4'h8;
    localparam logic [3:0] KEY_9    = 4'h9;
    localparam logic [3:0] KEY_OP_A = 4'hA;
    localparam logic [3:0] KEY_OP_B = 4'hB;
    localparam logic [3:0] KEY_OP_C = 4'hC;
    localparam logic [3:0] KEY_OP_D = 4'hD;
    localparam logic [3:0] KEY_OP_E = 4'hE;
    localparam logic [3:0] KEY_EQ   = 4'hF;

    localparam logic [3:0] COL_RESET = 4'b1110;

    // True when exactly one active-low line is asserted.
    function automatic logic one_low(input logic [3:0] lines);
        return $countones(~lines) == 1;
    endfunction

    // Index of the (highest) low line in an active-low group.
    function automatic logic [1:0] low_index(input logic [3:0] lines);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!lines[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for asynchronous level inputs.
// Resets to all-ones so idle pulled-up lines read as inactive.
module key_sync #(
    parameter int WIDTH = 1
) (
    input  logic             IN_clk,
    input  logic             IN_reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge IN_clk or negedge IN_reset) begin
        if (!IN_reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_scan.sv
// 4x4 keypad scanner with press/release debounce.
// Emits one OUT_key strobe per physical press.
module key_scan
    import key_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 500000
) (
    input  logic       IN_clk,
    input  logic       IN_reset,
    input  logic [3:0] IN_row,
    output logic [3:0] OUT_col,
    output logic [3:0] OUT_value,
    output logic       OUT_key,
    output logic [2:0] OUT_scan_state
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);

    logic [3:0]    row_s;
    scan_state_t   state, state_n;
    logic [3:0]    col, col_n;
    logic [3:0]    pat, pat_n;
    logic [3:0]    value, value_n;
    logic [1:0]    row_idx, row_idx_n;
    logic [DW-1:0] dwell, dwell_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    col_next;

    key_sync #(
        .WIDTH(4)
    ) u_sync (
        .IN_clk  (IN_clk),
        .IN_reset(IN_reset),
        .d       (IN_row),
        .q       (row_s)
    );

    assign col_next = {col[2:0], col[3]};

    // Next-state and datapath decisions for the scan FSM.
    always_comb begin
        state_n   = state;
        col_n     = col;
        pat_n     = pat;
        value_n   = value;
        row_idx_n = row_idx;
        dwell_n   = dwell;
        cnt_n     = cnt;
        unique case (state)
            SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_n = '0;
                    if (one_low(row_s)) begin
                        pat_n     = row_s;
                        row_idx_n = low_index(row_s);
                        cnt_n     = '0;
                        state_n   = DEBOUNCE;
                    end else begin
                        col_n = col_next;
                    end
                end else begin
                    dwell_n = dwell + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (row_s == pat) begin
                    if (cnt == CNT_LAST) begin
                        value_n = {row_idx, low_index(col)};
                        cnt_n   = '0;
                        state_n = PRESS;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end else begin
                    col_n   = col_next;
                    dwell_n = '0;
                    state_n = SCAN;
                end
            end
            PRESS: begin
                cnt_n   = '0;
                state_n = HELD;
            end
            HELD: begin
                if (row_s == 4'hF) begin
                    cnt_n   = '0;
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                if (row_s == 4'hF) begin
                    if (cnt == CNT_LAST) begin
                        col_n   = col_next;
                        dwell_n = '0;
                        state_n = SCAN;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end else begin
                    cnt_n   = '0;
                    state_n = HELD;
                end
            end
            default: begin
                col_n   = COL_RESET;
                dwell_n = '0;
                cnt_n   = '0;
                state_n = SCAN;
            end
        endcase
    end

    // State, column and counter registers.
    always_ff @(posedge IN_clk or negedge IN_reset) begin
        if (!IN_reset) begin
            state   <= SCAN;
            col     <= COL_RESET;
            pat     <= 4'hF;
            value   <= KEY_0;
            row_idx <= 2'd0;
            dwell   <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            col     <= col_n;
            pat     <= pat_n;
            value   <= value_n;
            row_idx <= row_idx_n;
            dwell   <= dwell_n;
            cnt     <= cnt_n;
        end
    end

    assign OUT_col        = col;
    assign OUT_value      = value;
    assign OUT_key        = (state == PRESS);
    assign OUT_scan_state = state;

endmodule
